// File: rtl/call_return_ctrl_pkg.sv
// Shared widths, vectors, FSM state encoding and request arbitration for the
// call/return sequencer.
package cpu_pkg;

    localparam int PC_W        = 9;
    localparam int FLAGS_W     = 4;
    localparam int STACK_DEPTH = 5;
    localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1);

    localparam logic [PC_W-1:0] IRQ_VEC   = 9'h004;
    localparam logic [PC_W-1:0] UFLOW_VEC = 9'h000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        JUMP = 2'd2,
        POP  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        GNT_NONE = 3'd0,
        GNT_IRQ  = 3'd1,
        GNT_RETI = 3'd2,
        GNT_CALL = 3'd3,
        GNT_RET  = 3'd4
    } grant_t;

    // Fixed priority: an unmasked interrupt beats RETI, which beats CALL,
    // which beats RET.
    function automatic grant_t arbitrate(
        input logic irq,
        input logic reti,
        input logic call,
        input logic ret,
        input logic irq_masked
    );
        if (irq && !irq_masked) return GNT_IRQ;
        if (reti)               return GNT_RETI;
        if (call)               return GNT_CALL;
        if (ret)                return GNT_RET;
        return GNT_NONE;
    endfunction

endpackage

// File: rtl/call_return_ctrl_if.sv
// Request/ack, stack-side and PC/flags-reload signals of the call/return
// sequencer. The controller uses the slave modport.
interface call_return_ctrl_if #(
    parameter int PC_W    = cpu_pkg::PC_W,
    parameter int FLAGS_W = cpu_pkg::FLAGS_W,
    parameter int DEPTH_W = cpu_pkg::DEPTH_W
);
    logic               call_req;
    logic               ret_req;
    logic               reti_req;
    logic               irq_req;
    logic [PC_W-1:0]    call_target;
    logic [PC_W-1:0]    cur_pc;
    logic [FLAGS_W-1:0] cur_flags;

    logic               call_ack;
    logic               ret_ack;
    logic               reti_ack;
    logic               irq_ack;
    logic               busy;

    logic               stk_push_en;
    logic               stk_pop_en;
    logic [PC_W-1:0]    stk_in_pc;
    logic [FLAGS_W-1:0] stk_in_flags;
    logic [PC_W-1:0]    stk_out_pc;
    logic [FLAGS_W-1:0] stk_out_flags;

    logic               pc_load_en;
    logic [PC_W-1:0]    pc_load_val;
    logic               flags_load_en;
    logic [FLAGS_W-1:0] flags_load_val;

    logic               in_service;
    logic [DEPTH_W-1:0] depth;
    logic               ovf_err;
    logic               ufl_err;

    modport master (
        output call_req, ret_req, reti_req, irq_req,
        output call_target, cur_pc, cur_flags,
        output stk_out_pc, stk_out_flags,
        input  call_ack, ret_ack, reti_ack, irq_ack, busy,
        input  stk_push_en, stk_pop_en, stk_in_pc, stk_in_flags,
        input  pc_load_en, pc_load_val, flags_load_en, flags_load_val,
        input  in_service, depth, ovf_err, ufl_err
    );

    modport slave (
        input  call_req, ret_req, reti_req, irq_req,
        input  call_target, cur_pc, cur_flags,
        input  stk_out_pc, stk_out_flags,
        output call_ack, ret_ack, reti_ack, irq_ack, busy,
        output stk_push_en, stk_pop_en, stk_in_pc, stk_in_flags,
        output pc_load_en, pc_load_val, flags_load_en, flags_load_val,
        output in_service, depth, ovf_err, ufl_err
    );

endinterface

// File: rtl/call_return_ctrl_stack_depth_ctr.sv
// Saturating occupancy counter for the return stack with sticky overflow and
// underflow flags.
module stack_depth_ctr #(
    parameter int DEPTH = cpu_pkg::STACK_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    output logic [CNT_W-1:0] depth,
    output logic             empty,
    output logic             ovf,
    output logic             ufl
);

    // A push into a full stack still happens (oldest entry is dropped), so
    // the count saturates; an empty pop attempt only raises the flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            depth <= '0;
            ovf   <= 1'b0;
            ufl   <= 1'b0;
        end else if (push) begin
            if (depth == CNT_W'(DEPTH)) begin
                ovf <= 1'b1;
            end else begin
                depth <= depth + CNT_W'(1);
            end
        end else if (pop) begin
            if (depth == '0) begin
                ufl <= 1'b1;
            end else begin
                depth <= depth - CNT_W'(1);
            end
        end
    end

    assign empty = (depth == '0);

endmodule

// File: rtl/call_return_ctrl.sv
// CALL/RET/IRQ/RETI sequencer: arbitrates requests in IDLE and issues ordered
// push/pop strobes and PC/flags reloads to the return stack and core.
module call_return_ctrl #(
    parameter int              PC_W      = cpu_pkg::PC_W,
    parameter int              FLAGS_W   = cpu_pkg::FLAGS_W,
    parameter int              DEPTH     = cpu_pkg::STACK_DEPTH,
    parameter logic [PC_W-1:0] IRQ_VEC   = cpu_pkg::IRQ_VEC,
    parameter logic [PC_W-1:0] UFLOW_VEC = cpu_pkg::UFLOW_VEC
) (
    input  logic               clk,
    input  logic               rst,
    call_return_ctrl_if.slave  bus
);
    import cpu_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    state_t             state;
    grant_t             gnt;
    logic               is_irq;
    logic               is_reti;
    logic               pop_try;
    logic [PC_W-1:0]    jump_tgt;

    logic               push_en_r;
    logic               pop_en_r;
    logic [PC_W-1:0]    in_pc_r;
    logic [FLAGS_W-1:0] in_flags_r;
    logic               pc_ld_r;
    logic [PC_W-1:0]    pc_val_r;
    logic               fl_ld_r;
    logic [FLAGS_W-1:0] fl_val_r;
    logic               in_svc_r;

    logic [CNT_W-1:0]   cnt;
    logic               empty;
    logic               ovf;
    logic               ufl;

    // Acks are the only outputs decoded from the inputs: they must pulse in
    // the same IDLE cycle in which the held request is accepted.
    always_comb begin
        gnt = GNT_NONE;
        if (state == IDLE && !rst) begin
            gnt = arbitrate(bus.irq_req, bus.reti_req, bus.call_req,
                            bus.ret_req, in_svc_r);
        end
    end

    assign bus.irq_ack  = (gnt == GNT_IRQ);
    assign bus.reti_ack = (gnt == GNT_RETI);
    assign bus.call_ack = (gnt == GNT_CALL);
    assign bus.ret_ack  = (gnt == GNT_RET);
    assign bus.busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (gnt == GNT_IRQ) begin
            jump_tgt <= IRQ_VEC;
        end else if (gnt == GNT_CALL) begin
            jump_tgt <= bus.call_target;
        end
    end

    // Strobes are decided one edge ahead so each is a clean registered pulse
    // for exactly the PUSH, JUMP or POP cycle it belongs to. The stack top and
    // occupancy sampled at acceptance are what POP sees, since nothing moves
    // the stack while in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            is_irq     <= 1'b0;
            is_reti    <= 1'b0;
            pop_try    <= 1'b0;
            push_en_r  <= 1'b0;
            pop_en_r   <= 1'b0;
            in_pc_r    <= '0;
            in_flags_r <= '0;
            pc_ld_r    <= 1'b0;
            pc_val_r   <= '0;
            fl_ld_r    <= 1'b0;
            fl_val_r   <= '0;
            in_svc_r   <= 1'b0;
        end else begin
            push_en_r <= 1'b0;
            pop_en_r  <= 1'b0;
            pop_try   <= 1'b0;
            pc_ld_r   <= 1'b0;
            fl_ld_r   <= 1'b0;
            case (state)
                IDLE: begin
                    case (gnt)
                        GNT_IRQ, GNT_CALL: begin
                            state      <= PUSH;
                            push_en_r  <= 1'b1;
                            is_irq     <= (gnt == GNT_IRQ);
                            in_pc_r    <= (gnt == GNT_IRQ) ? bus.cur_pc
                                                           : bus.cur_pc + PC_W'(1);
                            in_flags_r <= bus.cur_flags;
                        end
                        GNT_RETI, GNT_RET: begin
                            state    <= POP;
                            pop_try  <= 1'b1;
                            pop_en_r <= !empty;
                            pc_ld_r  <= 1'b1;
                            pc_val_r <= empty ? UFLOW_VEC : bus.stk_out_pc;
                            fl_ld_r  <= (gnt == GNT_RETI) && !empty;
                            fl_val_r <= bus.stk_out_flags;
                            is_reti  <= (gnt == GNT_RETI);
                        end
                        default: ;
                    endcase
                end
                PUSH: begin
                    state    <= JUMP;
                    pc_ld_r  <= 1'b1;
                    pc_val_r <= jump_tgt;
                    if (is_irq) begin
                        in_svc_r <= 1'b1;
                    end
                end
                JUMP: begin
                    state <= IDLE;
                end
                POP: begin
                    state <= IDLE;
                    if (is_reti) begin
                        in_svc_r <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    stack_depth_ctr #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_depth (
        .clk   (clk),
        .rst   (rst),
        .push  (push_en_r),
        .pop   (pop_try),
        .depth (cnt),
        .empty (empty),
        .ovf   (ovf),
        .ufl   (ufl)
    );

    assign bus.stk_push_en    = push_en_r;
    assign bus.stk_pop_en     = pop_en_r;
    assign bus.stk_in_pc      = in_pc_r;
    assign bus.stk_in_flags   = in_flags_r;
    assign bus.pc_load_en     = pc_ld_r;
    assign bus.pc_load_val    = pc_val_r;
    assign bus.flags_load_en  = fl_ld_r;
    assign bus.flags_load_val = fl_val_r;
    assign bus.in_service     = in_svc_r;
    assign bus.depth          = cnt;
    assign bus.ovf_err        = ovf;
    assign bus.ufl_err        = ufl;

endmodule

// File: tb/tb_call_return_ctrl.sv
// Directed bench for call_return_ctrl with a behavioural 5-entry return stack
// that drops its oldest entry on overflow.
module tb_call_return_ctrl;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    call_return_ctrl_if bus ();

    call_return_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [8:0] mem_pc [5] = '{default: '0};
    logic [3:0] mem_fl [5] = '{default: '0};

    always @(posedge clk) begin
        if (bus.stk_push_en) begin
            for (int i = 4; i > 0; i--) begin
                mem_pc[i] <= mem_pc[i-1];
                mem_fl[i] <= mem_fl[i-1];
            end
            mem_pc[0] <= bus.stk_in_pc;
            mem_fl[0] <= bus.stk_in_flags;
        end else if (bus.stk_pop_en) begin
            for (int i = 0; i < 4; i++) begin
                mem_pc[i] <= mem_pc[i+1];
                mem_fl[i] <= mem_fl[i+1];
            end
        end
    end

    assign bus.stk_out_pc    = mem_pc[0];
    assign bus.stk_out_flags = mem_fl[0];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {23'd0, bus.call_ack, bus.ret_ack, bus.reti_ack, bus.irq_ack, bus.busy,
                bus.stk_push_en, bus.stk_pop_en, bus.stk_in_pc, bus.stk_in_flags,
                bus.pc_load_en, bus.pc_load_val, bus.flags_load_en, bus.flags_load_val,
                bus.in_service, bus.depth, bus.ovf_err, bus.ufl_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // CALL (irq=0) or interrupt entry (irq=1), from acceptance back to IDLE.
    task automatic do_call(input logic [8:0] pc, input logic [8:0] tgt, input logic [3:0] fl,
                           input logic irq, input logic [8:0] exp_push, input logic [8:0] exp_tgt);
        bus.cur_pc      = pc;
        bus.cur_flags   = fl;
        bus.call_target = tgt;
        if (irq) bus.irq_req = 1'b1;
        else     bus.call_req = 1'b1;
        #1;
        chk("accept_ack", irq ? bus.irq_ack : bus.call_ack, 1);
        chk("accept_busy", bus.busy, 0);
        tick();
        bus.irq_req  = 1'b0;
        bus.call_req = 1'b0;
        chk("push_en", bus.stk_push_en, 1);
        chk("push_pc", bus.stk_in_pc, exp_push);
        chk("push_flags", bus.stk_in_flags, fl);
        chk("push_no_pcload", bus.pc_load_en, 0);
        tick();
        chk("jump_pcload", bus.pc_load_en, 1);
        chk("jump_pcval", bus.pc_load_val, exp_tgt);
        chk("jump_no_push", bus.stk_push_en, 0);
        tick();
        chk("call_idle_busy", bus.busy, 0);
        chk("call_idle_pcload", bus.pc_load_en, 0);
    endtask

    // RET (reti=0) or RETI (reti=1), from acceptance back to IDLE.
    task automatic do_ret(input logic reti, input logic [8:0] exp_pc, input logic exp_pop,
                          input logic exp_fl_ld, input logic [3:0] exp_fl);
        if (reti) bus.reti_req = 1'b1;
        else      bus.ret_req = 1'b1;
        #1;
        chk("ret_ack", reti ? bus.reti_ack : bus.ret_ack, 1);
        tick();
        bus.ret_req  = 1'b0;
        bus.reti_req = 1'b0;
        chk("pop_pcload", bus.pc_load_en, 1);
        chk("pop_pcval", bus.pc_load_val, exp_pc);
        chk("pop_en", bus.stk_pop_en, exp_pop);
        chk("pop_flload", bus.flags_load_en, exp_fl_ld);
        if (exp_fl_ld) chk("pop_flval", bus.flags_load_val, exp_fl);
        chk("pop_no_push", bus.stk_push_en, 0);
        tick();
        chk("ret_idle_busy", bus.busy, 0);
        chk("ret_idle_strobes", {bus.pc_load_en, bus.stk_pop_en, bus.flags_load_en}, 0);
    endtask

    initial begin
        rst             = 1'b1;
        bus.call_req    = 1'b0;
        bus.ret_req     = 1'b0;
        bus.reti_req    = 1'b0;
        bus.irq_req     = 1'b0;
        bus.call_target = '0;
        bus.cur_pc      = '0;
        bus.cur_flags   = '0;
        tick();
        tick();
        chk("reset_outputs", all_outs(), 0);
        rst = 1'b0;
        tick();

        // Basic CALL then RET
        do_call(9'h010, 9'h080, 4'b0101, 1'b0, 9'h011, 9'h080);
        chk("depth_after_call", bus.depth, 1);
        do_ret(1'b0, 9'h011, 1'b1, 1'b0, 4'b0000);
        chk("depth_after_ret", bus.depth, 0);
        chk("errs_clean", {bus.ovf_err, bus.ufl_err}, 0);

        // Overflow: six pushes into five entries
        for (int i = 1; i <= 6; i++) begin
            do_call(9'(i), 9'h100 + 9'(i), 4'(i), 1'b0, 9'(i + 1), 9'h100 + 9'(i));
            if (i == 5) chk("no_ovf_at_five", {bus.ovf_err, bus.depth}, {1'b0, 3'd5});
        end
        chk("ovf_set", bus.ovf_err, 1);
        chk("depth_saturated", bus.depth, 5);
        for (int k = 0; k < 5; k++) begin
            do_ret(1'b0, 9'(7 - k), 1'b1, 1'b0, 4'b0000);
        end
        chk("depth_drained", bus.depth, 0);
        chk("no_ufl_yet", bus.ufl_err, 0);
        do_ret(1'b0, 9'h000, 1'b0, 1'b0, 4'b0000);
        chk("ufl_set", bus.ufl_err, 1);
        chk("depth_empty", bus.depth, 0);

        rst = 1'b1;
        tick();
        chk("reset_clears_errs", all_outs(), 0);
        rst = 1'b0;
        tick();

        // PC wrap on CALL increment
        do_call(9'h1FF, 9'h055, 4'b0011, 1'b0, 9'h000, 9'h055);
        do_ret(1'b0, 9'h000, 1'b1, 1'b0, 4'b0000);
        chk("wrap_no_ufl", bus.ufl_err, 0);

        // Interrupt entry, masked second interrupt, RETI
        do_call(9'h020, 9'h1EE, 4'b1010, 1'b1, 9'h020, 9'h004);
        chk("in_service_set", bus.in_service, 1);
        bus.irq_req = 1'b1;
        #1;
        chk("irq_masked_ack", bus.irq_ack, 0);
        tick();
        chk("irq_masked_idle", {bus.busy, bus.stk_push_en}, 0);
        bus.irq_req = 1'b0;
        do_ret(1'b1, 9'h020, 1'b1, 1'b1, 4'b1010);
        chk("in_service_clr", bus.in_service, 0);
        chk("depth_after_reti", bus.depth, 0);

        // Simultaneous IRQ, CALL and RET
        bus.cur_pc      = 9'h030;
        bus.cur_flags   = 4'b0110;
        bus.call_target = 9'h0C0;
        bus.irq_req     = 1'b1;
        bus.call_req    = 1'b1;
        bus.ret_req     = 1'b1;
        #1;
        chk("prio_acks", {bus.irq_ack, bus.reti_ack, bus.call_ack, bus.ret_ack}, 4'b1000);
        tick();
        bus.irq_req = 1'b0;
        #1;
        chk("prio_push_wait", {bus.call_ack, bus.ret_ack, bus.stk_push_en}, 3'b001);
        chk("prio_irq_pc", bus.stk_in_pc, 9'h030);
        tick();
        chk("prio_jump_wait", {bus.call_ack, bus.ret_ack, bus.pc_load_en}, 3'b001);
        chk("prio_irq_vec", bus.pc_load_val, 9'h004);
        tick();
        chk("prio_call_ack", {bus.call_ack, bus.ret_ack}, 2'b10);
        tick();
        bus.call_req = 1'b0;
        #1;
        chk("prio_call_push", {bus.ret_ack, bus.stk_push_en}, 2'b01);
        chk("prio_call_pc", bus.stk_in_pc, 9'h031);
        tick();
        chk("prio_call_jump", bus.pc_load_val, 9'h0C0);
        chk("prio_ret_wait", bus.ret_ack, 0);
        tick();
        chk("prio_ret_ack", bus.ret_ack, 1);
        tick();
        bus.ret_req = 1'b0;
        chk("prio_ret_pop", {bus.stk_pop_en, bus.pc_load_en}, 2'b11);
        chk("prio_ret_pc", bus.pc_load_val, 9'h031);
        tick();
        chk("prio_final_depth", bus.depth, 1);
        chk("prio_in_service", bus.in_service, 1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Reset during the PUSH cycle of a CALL
        bus.cur_pc      = 9'h040;
        bus.call_target = 9'h0AA;
        bus.call_req    = 1'b1;
        #1;
        chk("abort_ack", bus.call_ack, 1);
        tick();
        chk("abort_in_push", bus.stk_push_en, 1);
        rst          = 1'b1;
        bus.call_req = 1'b0;
        tick();
        chk("abort_reset_outs", all_outs(), 0);
        rst = 1'b0;
        tick();
        chk("abort_no_strobe1", {bus.stk_push_en, bus.pc_load_en, bus.busy}, 0);
        tick();
        chk("abort_no_strobe2", {bus.stk_push_en, bus.pc_load_en, bus.busy, bus.depth}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
